rv32_pipe_cpu: RTL and testbench
================================

// Module: rv32_pipe_cpu
// PURPOSE
//  5-stage (IF/ID/EX/MEM/WB) in-order RV32I-subset integer core.
//  Fetches from an external combinational instruction memory through pc_out/instr_if.
//  Drives an external data memory with sync write and combinational read.
//  The data memory performs byte-lane steering and sign/zero extension selected by mem_op.
//  Holds the 32x32 register file internally as instance register_file_h, array registers[0:31].
// PARAMETERS
//  RESET_PC   32'h0000_0000   fetch address after reset
// PORTS
//  clk           in   1    single clock; all state updates on posedge
//  resetn        in   1    asynchronous, active-low reset
//  pc_out        out  32   IF-stage fetch address (byte address)
//  instr_if      in   32   instruction at pc_out, combinational
//  mem_wr_en     out  1    MEM-stage store strobe; memory writes on the next posedge
//  mem_op        out  3    mem_op_t: MEM_B=0, MEM_H=1, MEM_W=2, MEM_BU=4, MEM_HU=5
//  mem_addr      out  32   MEM-stage effective address, rs1+imm
//  mem_data_in   out  32   store data: rs2 unshifted; memory selects the low byte/half
//  mem_data_out  in   32   load data, already extended per mem_op; combinational
// BEHAVIOUR
//  - Reset (resetn=0, async): PC=RESET_PC, all pipeline registers cleared to bubble, x0..x31=0, mem_wr_en=0.
//    pc_out=RESET_PC and mem_addr=0 while in reset.
//  - Supported instructions:
//    LUI, AUIPC, JAL, JALR, BEQ, BNE;
//    ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI;
//    ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA;
//    LB/LH/LW/LBU/LHU; SB/SH/SW.
//  - Any other opcode executes as a NOP.
//  - One instruction enters per cycle; PC+=4 unless stalled or redirected. Writeback occurs in WB.
//  - Register file: x0 reads 0 and writes to it are ignored.
//    Write-before-read in the same cycle: ID sees the WB value.
//  - Forwarding into EX operands: EX/MEM result first, then MEM/WB result (including load data).
//  - Load-use hazard (a load in EX whose rd matches ID rs1/rs2, rd!=0):
//    hold PC and IF/ID for 1 cycle and insert a bubble into EX.
//  - Branches and jumps resolve in EX:
//    on taken/jump, PC<=target, flush IF/ID and ID/EX to bubble (2-cycle penalty).
//    JAL/JALR write PC+4. JALR target clears bit 0.
//  - Memory interface:
//    mem_wr_en=1 only for a store in MEM; loads take mem_data_out in MEM.
//    Addresses are byte addresses, little-endian. Misaligned access behaviour is undefined.
//  - Bubbles never assert mem_wr_en or a register write.
// TESTING (PC=0 program; bench holds resetn low for 10ns, then runs 100 cycles)
//  1 lui x5,0x12345; addi x5,x5,0x678; sw x5,0(x0); lw x10,0(x0)
//    -> x10=32'h12345678 (store then load, with forwarding).
//  2 lbu x11,2(x0) and lb x12,2(x0)
//    -> x11=x12=32'h00000034.
//  3 addi x6,x0,0xAA; sb x6,0(x0); lw x13,0(x0)
//    -> x13=32'h123456AA; byte store leaves the other lanes intact.
//  4 lw x7,0(x0); addi x8,x7,1 back-to-back
//    -> x8=32'h123456AB; exactly one stall cycle.
//  5 beq x0,x0,+8 with addi x9,x0,1 in the shadow
//    -> x9 stays 0 (flush); JAL to itself holds the PC loop.
//  6 Assert resetn mid-run
//    -> pc_out=0 immediately, no mem_wr_en, all x-registers read 0.

Source files
------------

// File: rtl/rv32_pipe_cpu.sv
// rv32_pipe_cpu: 5-stage RV32I-subset pipeline with EX forwarding, load-use stall and EX-resolved branches
module rv32_regfile (
    input  logic        clk,
    input  logic        resetn,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic [31:0] rs1_val,
    output logic [31:0] rs2_val,
    input  logic        we,
    input  logic [4:0]  rd,
    input  logic [31:0] wd
);
    logic [31:0] registers [0:31];
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) registers[i] <= '0;
        end else if (we && rd != 5'd0) begin
            registers[rd] <= wd;
        end
    end
    // same-cycle WB write is visible to the ID read
    assign rs1_val = (rs1 == 5'd0) ? '0 : (we && rd == rs1) ? wd : registers[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : (we && rd == rs2) ? wd : registers[rs2];
endmodule

module rv32_pipe_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [31:0] pc_out,
    input  logic [31:0] instr_if,
    output logic        mem_wr_en,
    output logic [2:0]  mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;

    typedef struct packed {
        logic       reg_we;
        logic       mem_rd;
        logic       mem_wr;
        logic       beq;
        logic       bne;
        logic       jal;
        logic       jalr;
        logic       b_imm;
        logic [1:0] a_sel;
        logic [3:0] alu_op;
        logic [2:0] mem_op;
    } ctrl_t;

    logic [31:0] pc, if_id_pc, if_id_instr;
    logic [31:0] id_ex_pc, id_ex_imm, id_ex_rs1_val, id_ex_rs2_val;
    logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
    ctrl_t       id_ex_ctrl, d_ctrl;
    logic [31:0] ex_mem_result, ex_mem_store;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_reg_we, ex_mem_mem_rd, ex_mem_mem_wr;
    logic [2:0]  ex_mem_mem_op;
    logic [31:0] mem_wb_data;
    logic [4:0]  mem_wb_rd;
    logic        mem_wb_reg_we;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, d_imm;
    logic [31:0] rf_rs1, rf_rs2;
    logic [31:0] fwd_a, fwd_b, alu_a, alu_b, alu_res, ex_result, target;
    logic        stall, redirect, eq;

    rv32_regfile register_file_h (
        .clk     (clk),
        .resetn  (resetn),
        .rs1     (if_id_instr[19:15]),
        .rs2     (if_id_instr[24:20]),
        .rs1_val (rf_rs1),
        .rs2_val (rf_rs2),
        .we      (mem_wb_reg_we),
        .rd      (mem_wb_rd),
        .wd      (mem_wb_data)
    );

    assign opcode = if_id_instr[6:0];
    assign funct3 = if_id_instr[14:12];
    assign imm_i  = {{20{if_id_instr[31]}}, if_id_instr[31:20]};
    assign imm_s  = {{20{if_id_instr[31]}}, if_id_instr[31:25], if_id_instr[11:7]};
    assign imm_b  = {{19{if_id_instr[31]}}, if_id_instr[31], if_id_instr[7], if_id_instr[30:25],
                     if_id_instr[11:8], 1'b0};
    assign imm_u  = {if_id_instr[31:12], 12'b0};
    assign imm_j  = {{11{if_id_instr[31]}}, if_id_instr[31], if_id_instr[19:12], if_id_instr[20],
                     if_id_instr[30:21], 1'b0};

    // a_sel: 0 = rs1, 1 = pc, 2 = zero; the ALU also forms jump/branch targets
    always_comb begin
        d_ctrl = '0;
        d_imm  = imm_i;
        case (opcode)
            OP_LUI: begin
                d_ctrl.reg_we = 1'b1;
                d_ctrl.a_sel  = 2'd2;
                d_ctrl.b_imm  = 1'b1;
                d_imm         = imm_u;
            end
            OP_AUIPC: begin
                d_ctrl.reg_we = 1'b1;
                d_ctrl.a_sel  = 2'd1;
                d_ctrl.b_imm  = 1'b1;
                d_imm         = imm_u;
            end
            OP_JAL: begin
                d_ctrl.reg_we = 1'b1;
                d_ctrl.jal    = 1'b1;
                d_ctrl.a_sel  = 2'd1;
                d_ctrl.b_imm  = 1'b1;
                d_imm         = imm_j;
            end
            OP_JALR: begin
                d_ctrl.reg_we = 1'b1;
                d_ctrl.jalr   = 1'b1;
                d_ctrl.b_imm  = 1'b1;
            end
            OP_BRANCH: begin
                d_ctrl.beq    = funct3 == 3'd0;
                d_ctrl.bne    = funct3 == 3'd1;
                d_ctrl.a_sel  = 2'd1;
                d_ctrl.b_imm  = 1'b1;
                d_imm         = imm_b;
            end
            OP_LOAD: begin
                d_ctrl.reg_we = !(funct3 == 3'd3 || funct3[2:1] == 2'b11);
                d_ctrl.mem_rd = !(funct3 == 3'd3 || funct3[2:1] == 2'b11);
                d_ctrl.b_imm  = 1'b1;
                d_ctrl.mem_op = funct3;
            end
            OP_STORE: begin
                d_ctrl.mem_wr = funct3 < 3'd3;
                d_ctrl.b_imm  = 1'b1;
                d_ctrl.mem_op = funct3;
                d_imm         = imm_s;
            end
            OP_IMM: begin
                d_ctrl.reg_we = 1'b1;
                d_ctrl.b_imm  = 1'b1;
                d_ctrl.alu_op = {funct3 == 3'b101 && if_id_instr[30], funct3};
            end
            OP_REG: begin
                d_ctrl.reg_we = 1'b1;
                d_ctrl.alu_op = {if_id_instr[30], funct3};
            end
            default: ;
        endcase
    end

    assign stall = id_ex_ctrl.mem_rd && id_ex_rd != 5'd0 &&
                   (id_ex_rd == if_id_instr[19:15] || id_ex_rd == if_id_instr[24:20]);

    assign fwd_a = (ex_mem_reg_we && ex_mem_rd != 5'd0 && ex_mem_rd == id_ex_rs1) ? ex_mem_result :
                   (mem_wb_reg_we && mem_wb_rd != 5'd0 && mem_wb_rd == id_ex_rs1) ? mem_wb_data : id_ex_rs1_val;
    assign fwd_b = (ex_mem_reg_we && ex_mem_rd != 5'd0 && ex_mem_rd == id_ex_rs2) ? ex_mem_result :
                   (mem_wb_reg_we && mem_wb_rd != 5'd0 && mem_wb_rd == id_ex_rs2) ? mem_wb_data : id_ex_rs2_val;
    assign alu_a = (id_ex_ctrl.a_sel == 2'd1) ? id_ex_pc : (id_ex_ctrl.a_sel == 2'd2) ? '0 : fwd_a;
    assign alu_b = id_ex_ctrl.b_imm ? id_ex_imm : fwd_b;

    always_comb begin
        casez (id_ex_ctrl.alu_op)
            4'b1000: alu_res = alu_a - alu_b;
            4'b?001: alu_res = alu_a << alu_b[4:0];
            4'b?010: alu_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
            4'b?011: alu_res = {31'b0, alu_a < alu_b};
            4'b?100: alu_res = alu_a ^ alu_b;
            4'b0101: alu_res = alu_a >> alu_b[4:0];
            4'b1101: alu_res = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            4'b?110: alu_res = alu_a | alu_b;
            4'b?111: alu_res = alu_a & alu_b;
            default: alu_res = alu_a + alu_b;
        endcase
    end

    assign eq        = fwd_a == fwd_b;
    assign redirect  = id_ex_ctrl.jal || id_ex_ctrl.jalr || (id_ex_ctrl.beq && eq) || (id_ex_ctrl.bne && !eq);
    assign target    = {alu_res[31:1], 1'b0};
    assign ex_result = (id_ex_ctrl.jal || id_ex_ctrl.jalr) ? id_ex_pc + 32'd4 : alu_res;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc          <= RESET_PC;
            if_id_pc    <= '0;
            if_id_instr <= '0;
        end else if (redirect) begin
            pc          <= target;
            if_id_instr <= '0;
        end else if (!stall) begin
            pc          <= pc + 32'd4;
            if_id_pc    <= pc;
            if_id_instr <= instr_if;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            id_ex_ctrl    <= '0;
            id_ex_pc      <= '0;
            id_ex_imm     <= '0;
            id_ex_rs1_val <= '0;
            id_ex_rs2_val <= '0;
            id_ex_rs1     <= '0;
            id_ex_rs2     <= '0;
            id_ex_rd      <= '0;
        end else begin
            id_ex_ctrl    <= (redirect || stall) ? '0 : d_ctrl;
            id_ex_pc      <= if_id_pc;
            id_ex_imm     <= d_imm;
            id_ex_rs1_val <= rf_rs1;
            id_ex_rs2_val <= rf_rs2;
            id_ex_rs1     <= if_id_instr[19:15];
            id_ex_rs2     <= if_id_instr[24:20];
            id_ex_rd      <= if_id_instr[11:7];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_mem_reg_we <= 1'b0;
            ex_mem_mem_rd <= 1'b0;
            ex_mem_mem_wr <= 1'b0;
            ex_mem_mem_op <= '0;
            ex_mem_rd     <= '0;
            ex_mem_result <= '0;
            ex_mem_store  <= '0;
            mem_wb_reg_we <= 1'b0;
            mem_wb_rd     <= '0;
            mem_wb_data   <= '0;
        end else begin
            ex_mem_reg_we <= id_ex_ctrl.reg_we;
            ex_mem_mem_rd <= id_ex_ctrl.mem_rd;
            ex_mem_mem_wr <= id_ex_ctrl.mem_wr;
            ex_mem_mem_op <= id_ex_ctrl.mem_op;
            ex_mem_rd     <= id_ex_rd;
            ex_mem_result <= ex_result;
            ex_mem_store  <= fwd_b;
            mem_wb_reg_we <= ex_mem_reg_we;
            mem_wb_rd     <= ex_mem_rd;
            mem_wb_data   <= ex_mem_mem_rd ? mem_data_out : ex_mem_result;
        end
    end

    assign pc_out      = pc;
    assign mem_wr_en   = ex_mem_mem_wr;
    assign mem_op      = ex_mem_mem_op;
    assign mem_addr    = ex_mem_result;
    assign mem_data_in = ex_mem_store;
endmodule

// File: tb/tb_rv32_pipe_cpu.sv
// tb_rv32_pipe_cpu: directed program bench with instruction/data memory models for rv32_pipe_cpu
module tb_rv32_pipe_cpu;
    localparam logic [6:0] OPI = 7'b0010011, LD = 7'b0000011;
    logic        clk = 1'b0, resetn = 1'b0;
    logic [31:0] pc_out, instr_if, mem_addr, mem_data_in, mem_data_out;
    logic        mem_wr_en;
    logic [2:0]  mem_op;
    logic [31:0] imem [0:63];
    logic [31:0] dmem [0:63];
    logic [31:0] rd_word, rd_sh, wr_word, prev_pc = '0, acc;
    logic        track = 1'b0, ok;
    int          checks = 0, failures = 0, holds = 0, stores = 0;

    rv32_pipe_cpu dut (
        .clk          (clk),
        .resetn       (resetn),
        .pc_out       (pc_out),
        .instr_if     (instr_if),
        .mem_wr_en    (mem_wr_en),
        .mem_op       (mem_op),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;
    assign instr_if = imem[pc_out[7:2]];

    always_comb begin
        rd_word = dmem[mem_addr[7:2]];
        rd_sh   = rd_word >> {mem_addr[1:0], 3'b000};
        case (mem_op)
            3'd0:    mem_data_out = {{24{rd_sh[7]}}, rd_sh[7:0]};
            3'd1:    mem_data_out = {{16{rd_sh[15]}}, rd_sh[15:0]};
            3'd4:    mem_data_out = {24'b0, rd_sh[7:0]};
            3'd5:    mem_data_out = {16'b0, rd_sh[15:0]};
            default: mem_data_out = rd_word;
        endcase
        wr_word = rd_word;
        case (mem_op)
            3'd0:    wr_word[{mem_addr[1:0], 3'b000} +: 8] = mem_data_in[7:0];
            3'd1:    wr_word[{mem_addr[1], 4'b0000} +: 16] = mem_data_in[15:0];
            default: wr_word = mem_data_in;
        endcase
    end

    always @(posedge clk) if (mem_wr_en) dmem[mem_addr[7:2]] <= wr_word;

    always @(negedge clk) begin
        if (track && pc_out < 32'd100 && pc_out == prev_pc) holds <= holds + 1;
        if (track && mem_wr_en) stores <= stores + 1;
        prev_pc <= pc_out;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) begin
            imem[i] = 32'h0000_0013;
            dmem[i] = '0;
        end
        imem[0]  = {20'h12345, 5'd5, 7'b0110111};
        imem[1]  = enc_i(12'h678, 5, 0, 5, OPI);
        imem[2]  = enc_s(12'd0, 5, 0, 3'd2);
        imem[3]  = enc_i(12'd0, 0, 2, 10, LD);
        imem[4]  = enc_i(12'd2, 0, 4, 11, LD);
        imem[5]  = enc_i(12'd2, 0, 0, 12, LD);
        imem[6]  = enc_i(12'h0AA, 0, 0, 6, OPI);
        imem[7]  = enc_s(12'd0, 6, 0, 3'd0);
        imem[8]  = enc_i(12'd0, 0, 2, 13, LD);
        imem[9]  = enc_i(12'd0, 0, 2, 7, LD);
        imem[10] = enc_i(12'd1, 7, 0, 8, OPI);
        imem[11] = enc_i(12'hFF8, 0, 0, 14, OPI);
        imem[12] = enc_i(12'h401, 14, 5, 15, OPI);
        imem[13] = enc_i(12'd28, 14, 5, 16, OPI);
        imem[14] = enc_r(7'h20, 14, 16, 0, 17);
        imem[15] = enc_r(7'h00, 16, 14, 2, 18);
        imem[16] = enc_r(7'h00, 16, 14, 3, 19);
        imem[17] = enc_r(7'h00, 16, 14, 4, 20);
        imem[18] = enc_r(7'h00, 16, 14, 7, 21);
        imem[19] = enc_r(7'h00, 16, 5, 6, 22);
        imem[20] = enc_i(12'd4, 16, 1, 23, OPI);
        imem[21] = enc_r(7'h00, 16, 16, 1, 24);
        imem[22] = enc_r(7'h20, 16, 14, 5, 25);
        imem[23] = {20'h00001, 5'd26, 7'b0010111};
        imem[24] = enc_i(12'd2, 0, 1, 27, LD);
        imem[25] = enc_b(13'd8, 0, 0, 3'd1);
        imem[26] = enc_i(12'd5, 0, 0, 29, OPI);
        imem[27] = enc_i(12'd121, 0, 0, 30, 7'b1100111);
        imem[28] = enc_i(12'd1, 0, 0, 9, OPI);
        imem[29] = enc_i(12'd2, 0, 0, 9, OPI);
        imem[30] = enc_b(13'd8, 0, 0, 3'd0);
        imem[31] = enc_i(12'd1, 0, 0, 9, OPI);
        imem[32] = enc_j(21'd0, 0);
        #1;
        check("reset_pc", pc_out, 32'h0);
        check("reset_wr_en", {31'b0, mem_wr_en}, 32'h0);
        check("reset_addr", mem_addr, 32'h0);
        #9 resetn = 1'b1;
        @(posedge clk);
        track = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        track = 1'b0;
        check("x5_lui_addi", dut.register_file_h.registers[5], 32'h12345678);
        check("x10_sw_lw", dut.register_file_h.registers[10], 32'h12345678);
        check("x11_lbu", dut.register_file_h.registers[11], 32'h00000034);
        check("x12_lb", dut.register_file_h.registers[12], 32'h00000034);
        check("x6_addi", dut.register_file_h.registers[6], 32'h000000AA);
        check("x13_sb_lw", dut.register_file_h.registers[13], 32'h123456AA);
        check("x7_lw", dut.register_file_h.registers[7], 32'h123456AA);
        check("x8_load_use", dut.register_file_h.registers[8], 32'h123456AB);
        check("x14_addi_neg", dut.register_file_h.registers[14], 32'hFFFFFFF8);
        check("x15_srai", dut.register_file_h.registers[15], 32'hFFFFFFFC);
        check("x16_srli", dut.register_file_h.registers[16], 32'h0000000F);
        check("x17_sub", dut.register_file_h.registers[17], 32'h00000017);
        check("x18_slt", dut.register_file_h.registers[18], 32'h00000001);
        check("x19_sltu", dut.register_file_h.registers[19], 32'h00000000);
        check("x20_xor", dut.register_file_h.registers[20], 32'hFFFFFFF7);
        check("x21_and", dut.register_file_h.registers[21], 32'h00000008);
        check("x22_or", dut.register_file_h.registers[22], 32'h1234567F);
        check("x23_slli", dut.register_file_h.registers[23], 32'h000000F0);
        check("x24_sll", dut.register_file_h.registers[24], 32'h00078000);
        check("x25_sra", dut.register_file_h.registers[25], 32'hFFFFFFFF);
        check("x26_auipc", dut.register_file_h.registers[26], 32'h0000105C);
        check("x27_lh", dut.register_file_h.registers[27], 32'h00001234);
        check("x29_bne_not_taken", dut.register_file_h.registers[29], 32'h00000005);
        check("x30_jalr_link", dut.register_file_h.registers[30], 32'h00000070);
        check("x9_flushed", dut.register_file_h.registers[9], 32'h00000000);
        check("x0_zero", dut.register_file_h.registers[0], 32'h00000000);
        check("dmem0", dmem[0], 32'h123456AA);
        check("stall_cycles", holds, 1);
        check("store_strobes", stores, 2);
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ok &= (pc_out == 32'd128 || pc_out == 32'd132 || pc_out == 32'd136);
        end
        check("jal_loop_pc", {31'b0, ok}, 32'h1);
        #2 resetn = 1'b0;
        #1;
        check("midrun_pc", pc_out, 32'h0);
        check("midrun_addr", mem_addr, 32'h0);
        acc = '0;
        for (int i = 0; i < 32; i++) acc |= dut.register_file_h.registers[i];
        check("midrun_regs", acc, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 20 && !mem_wr_en; i++) @(negedge clk);
        check("rerun_store_seen", {31'b0, mem_wr_en}, 32'h1);
        resetn = 1'b0;
        #1;
        check("store_reset_wr_en", {31'b0, mem_wr_en}, 32'h0);
        check("store_reset_pc", pc_out, 32'h0);
        @(posedge clk);
        #1;
        check("store_killed", dmem[0], 32'h123456AA);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
